// File: rtl/rr_reg_arbiter.sv
// rr_reg_arbiter: round-robin arbitration of N_REQ writers onto one shared WIDTH-bit register, with bounded lock bursts.
// Latency: request sampled on edge t; the gnt pulse and the new q are both visible after edge t (one register stage).
// Backpressure: losers keep req high and wait; while locked only the owner is served, all other requests stay pending.
//
// Ports:
//   clk    - system clock, all state on rising edge
//   rst    - asynchronous reset, active-low
//   req    - per-requester write request (level, held until granted)
//   lock   - per-requester lock request, sampled together with req
//   wdata  - packed write data, slice i = wdata[i*WIDTH +: WIDTH]
//   gnt    - registered one-hot grant pulse, one cycle per write
//   q      - shared register contents
//   owner  - index of the last granted requester
//   locked - high while a requester holds the lock
module rr_reg_arbiter #(
   parameter int N_REQ    = 4,
   parameter int WIDTH    = 8,
   parameter int MAX_LOCK = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ-1:0]         lock,
   input  logic [N_REQ*WIDTH-1:0]   wdata,
   output logic [N_REQ-1:0]         gnt,
   output logic [WIDTH-1:0]         q,
   output logic [$clog2(N_REQ)-1:0] owner,
   output logic                     locked
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam int CNT_W = $clog2(MAX_LOCK + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_LOCK - 1);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [IDX_W-1:0]   r_ptr;
   logic [IDX_W-1:0]   r_owner;
   logic [CNT_W-1:0]   r_lock_cnt;
   logic [N_REQ-1:0]   r_gnt;
   logic [WIDTH-1:0]   r_q;

   logic               w_rr_vld;
   logic [IDX_W-1:0]   w_rr_idx;
   logic [IDX_W:0]     w_sum;
   logic [IDX_W-1:0]   w_cand;

   logic               w_wr;
   logic [IDX_W-1:0]   w_sel;
   logic               w_ptr_upd;
   logic               w_cnt_clr;
   logic               w_cnt_inc;
   logic [WIDTH-1:0]   w_wdat;
   logic [N_REQ-1:0]   w_onehot;

   // Round-robin search starting just after r_ptr. The loop runs from the
   // farthest candidate down to the nearest so the nearest set request is
   // the last assignment and therefore wins.
   always_comb begin
      w_rr_vld = 1'b0;
      w_rr_idx = '0;
      w_sum    = '0;
      w_cand   = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         w_sum = {1'b0, r_ptr} + (IDX_W+1)'(k);
         if (w_sum >= (IDX_W+1)'(N_REQ)) begin
            w_sum = w_sum - (IDX_W+1)'(N_REQ);
         end
         w_cand = w_sum[IDX_W-1:0];
         if (req[w_cand]) begin
            w_rr_vld = 1'b1;
            w_rr_idx = w_cand;
         end
      end
   end

   // Next-state and write control.
   always_comb begin
      w_state_nxt = r_state;
      w_wr        = 1'b0;
      w_sel       = r_owner;
      w_ptr_upd   = 1'b0;
      w_cnt_clr   = 1'b0;
      w_cnt_inc   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_rr_vld) begin
               w_wr      = 1'b1;
               w_sel     = w_rr_idx;
               w_ptr_upd = 1'b1;
               if (lock[w_rr_idx]) begin
                  w_state_nxt = ST_LOCKED;
                  w_cnt_clr   = 1'b1;
               end
            end
         end
         ST_LOCKED: begin
            // Owner may still write in the exit cycle; its lock bit is not
            // re-examined for re-entry, so re-locking needs a fresh IDLE win.
            w_wr      = req[r_owner];
            w_cnt_inc = 1'b1;
            if (!lock[r_owner] || (r_lock_cnt == CNT_LAST)) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign w_wdat   = wdata[int'(w_sel)*WIDTH +: WIDTH];
   assign w_onehot = N_REQ'(1) << w_sel;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_gnt      <= '0;
         r_q        <= '0;
         r_owner    <= '0;
         r_ptr      <= IDX_W'(N_REQ - 1);
         r_lock_cnt <= '0;
      end else begin
         r_gnt <= w_wr ? w_onehot : '0;
         if (w_wr) begin
            r_q     <= w_wdat;
            r_owner <= w_sel;
         end
         if (w_ptr_upd) begin
            r_ptr <= w_sel;
         end
         if (w_cnt_clr) begin
            r_lock_cnt <= '0;
         end else if (w_cnt_inc) begin
            r_lock_cnt <= r_lock_cnt + CNT_W'(1);
         end
      end
   end

   assign gnt    = r_gnt;
   assign q      = r_q;
   assign owner  = r_owner;
   assign locked = (r_state == ST_LOCKED);

endmodule
